// File: rtl/square_seq_pkg.sv
// Shared types and constants for the square-wave note sequencer.
package square_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } seq_state_t;

  // Storage width of the duration field inside a FIFO entry; the top-level
  // DUR_W parameter must not exceed it (narrower durations are zero-extended).
  localparam int NOTE_DUR_W = 16;

  // Duty codes understood by the downstream square-wave oscillator.
  localparam logic [1:0] DUTY_12_5 = 2'd0;
  localparam logic [1:0] DUTY_25   = 2'd1;
  localparam logic [1:0] DUTY_50   = 2'd2;
  localparam logic [1:0] DUTY_75   = 2'd3;

  // One queued note.
  typedef struct packed {
    logic                  rest;
    logic [NOTE_DUR_W-1:0] dur;
    logic [1:0]            duty;
    logic [15:0]           step;
  } note_t;

  // A zero duration plays as one tick.
  function automatic logic [NOTE_DUR_W-1:0] dur_min1(input logic [NOTE_DUR_W-1:0] d);
    logic [NOTE_DUR_W-1:0] r;
    if (d == {NOTE_DUR_W{1'b0}}) begin
      r = {{(NOTE_DUR_W-1){1'b0}}, 1'b1};
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO with flush; pointers carry one wrap bit so that
// full and empty are told apart without a separate counter.
module note_fifo
  import square_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  note_t                  wr_data,
  output note_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  note_t       r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  // Status decode and qualified push/pop; a flush drops any coincident push.
  always_comb begin
    empty   = (r_wr_ptr == r_rd_ptr);
    full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    level   = r_wr_ptr - r_rd_ptr;
    w_push  = push && !full && !flush;
    w_pop   = pop && !empty;
    rd_data = r_mem[r_rd_ptr[AW-1:0]];
  end

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/square_sequencer.sv
// Note sequencer: plays queued notes back-to-back on a tick timebase and
// drives the pitch, duty and phase restart of a square-wave oscillator.
module square_sequencer
  import square_seq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 48000,
  parameter int DUR_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [15:0]            note_step,
  input  logic [1:0]             note_duty,
  input  logic [DUR_W-1:0]       note_dur,
  input  logic                   note_rest,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  output logic [15:0]            step,
  output logic [1:0]             duty,
  output logic                   gate,
  output logic                   phase_clr,
  output logic                   note_done,
  output logic                   underrun,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [PW-1:0]    r_presc;
  logic [DUR_W-1:0] r_dur_cnt;

  logic             w_full;
  logic             w_empty;
  note_t            w_head;
  note_t            w_push_note;
  logic             w_tick;
  logic             w_last;
  logic             w_pop;

  logic [15:0]      r_step;
  logic [1:0]       r_duty;
  logic             r_gate;
  logic             r_phase_clr;
  logic             r_note_done;
  logic             r_underrun;
  logic             r_busy;

  logic [15:0]      w_step_nxt;
  logic [1:0]       w_duty_nxt;
  logic             w_gate_nxt;
  logic             w_phase_clr_nxt;
  logic             w_note_done_nxt;
  logic             w_underrun_nxt;

  // Pack the offered note into a FIFO entry.
  always_comb begin
    w_push_note      = '{default: 1'b0};
    w_push_note.rest = note_rest;
    w_push_note.dur  = NOTE_DUR_W'(note_dur);
    w_push_note.duty = note_duty;
    w_push_note.step = note_step;
  end

  note_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (note_valid),
    .pop     (w_pop),
    .flush   (flush),
    .wr_data (w_push_note),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  // Tick, end-of-note and pop decode; stop suppresses any pending pop.
  always_comb begin
    w_tick = (r_state == PLAY) && (r_presc == PW'(TICK_DIV - 1));
    w_last = w_tick && (r_dur_cnt == DUR_W'(1));
    if (stop) begin
      w_pop = 1'b0;
    end else if ((r_state == ARMED) || w_last) begin
      w_pop = !w_empty;
    end else begin
      w_pop = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; stop wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = start ? ARMED : IDLE;
        ARMED:   w_state_nxt = w_empty ? ARMED : PLAY;
        PLAY:    w_state_nxt = (w_last && w_empty) ? ARMED : PLAY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM output logic: next values for the registered oscillator controls.
  always_comb begin
    w_step_nxt      = r_step;
    w_duty_nxt      = r_duty;
    w_gate_nxt      = r_gate;
    w_phase_clr_nxt = 1'b0;
    w_note_done_nxt = 1'b0;
    w_underrun_nxt  = 1'b0;
    if (stop) begin
      w_step_nxt = 16'h0000;
      w_gate_nxt = 1'b0;
    end else if (w_pop) begin
      w_step_nxt      = w_head.rest ? 16'h0000 : w_head.step;
      w_duty_nxt      = w_head.duty;
      w_gate_nxt      = !w_head.rest;
      w_phase_clr_nxt = 1'b1;
      w_note_done_nxt = w_last;
    end else if (w_last) begin
      w_step_nxt      = 16'h0000;
      w_gate_nxt      = 1'b0;
      w_note_done_nxt = 1'b1;
      w_underrun_nxt  = 1'b1;
    end else begin
      w_step_nxt = r_step;
    end
  end

  // Prescaler and duration counter; both restart whenever a note loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= {PW{1'b0}};
      r_dur_cnt <= {DUR_W{1'b0}};
    end else if (w_pop) begin
      r_presc   <= {PW{1'b0}};
      r_dur_cnt <= DUR_W'(dur_min1(w_head.dur));
    end else if ((r_state == PLAY) && !stop) begin
      if (w_tick) begin
        r_presc   <= {PW{1'b0}};
        r_dur_cnt <= r_dur_cnt - DUR_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else begin
      r_presc <= {PW{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step      <= 16'h0000;
      r_duty      <= 2'd0;
      r_gate      <= 1'b0;
      r_phase_clr <= 1'b0;
      r_note_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_step      <= w_step_nxt;
      r_duty      <= w_duty_nxt;
      r_gate      <= w_gate_nxt;
      r_phase_clr <= w_phase_clr_nxt;
      r_note_done <= w_note_done_nxt;
      r_underrun  <= w_underrun_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign step       = r_step;
  assign duty       = r_duty;
  assign gate       = r_gate;
  assign phase_clr  = r_phase_clr;
  assign note_done  = r_note_done;
  assign underrun   = r_underrun;
  assign busy       = r_busy;
  assign note_ready = !w_full;

endmodule

// File: tb/tb_square_sequencer.sv
// Scoreboard bench for square_sequencer (DEPTH=4, TICK_DIV=4).
module tb_square_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        note_valid;
  logic        note_ready;
  logic [15:0] note_step;
  logic [1:0]  note_duty;
  logic [7:0]  note_dur;
  logic        note_rest;
  logic        start;
  logic        stop;
  logic        flush;
  logic [15:0] step;
  logic [1:0]  duty;
  logic        gate;
  logic        phase_clr;
  logic        note_done;
  logic        underrun;
  logic        busy;
  logic [2:0]  level;

  square_sequencer #(
    .DEPTH    (4),
    .TICK_DIV (4),
    .DUR_W    (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_step  (note_step),
    .note_duty  (note_duty),
    .note_dur   (note_dur),
    .note_rest  (note_rest),
    .start      (start),
    .stop       (stop),
    .flush      (flush),
    .step       (step),
    .duty       (duty),
    .gate       (gate),
    .phase_clr  (phase_clr),
    .note_done  (note_done),
    .underrun   (underrun),
    .busy       (busy),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Expected event: a note start (phase_clr) or an underrun.
  // gap = cycles since the previous phase_clr, -1 when not checked.
  typedef struct {
    bit          is_ur;
    logic [15:0] step;
    logic [1:0]  duty;
    logic        gate;
    int          gap;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_pc(input logic [15:0] s, input logic [1:0] d, input logic g, input int gap);
    ev_t e;
    e.is_ur = 1'b0; e.step = s; e.duty = d; e.gate = g; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic exp_ur(input int gap);
    ev_t e;
    e.is_ur = 1'b1; e.step = 16'h0000; e.duty = 2'd0; e.gate = 1'b0; e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every phase_clr/underrun, checks spacing,
  // and checks the sounding note is held steady between events.
  int          mon_cyc  = 0;
  int          last_pc  = 0;
  bit          active   = 1'b0;
  logic [15:0] cur_step;
  logic        cur_gate;
  ev_t         mon_e;

  always @(negedge clk) begin
    mon_cyc++;
    if (!reset_n) begin
      active = 1'b0;
    end else if (phase_clr || underrun) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, phase_clr, underrun}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {31'd0, underrun}, {31'd0, mon_e.is_ur});
        if (mon_e.gap >= 0) begin
          chk("event_gap", mon_cyc - last_pc, mon_e.gap);
          chk("event_note_done", {31'd0, note_done}, 32'd1);
        end
        if (phase_clr) begin
          chk("pc_step", {16'd0, step}, {16'd0, mon_e.step});
          chk("pc_duty", {30'd0, duty}, {30'd0, mon_e.duty});
          chk("pc_gate", {31'd0, gate}, {31'd0, mon_e.gate});
          last_pc  = mon_cyc;
          active   = 1'b1;
          cur_step = mon_e.step;
          cur_gate = mon_e.gate;
        end else begin
          chk("ur_step", {16'd0, step}, 32'd0);
          chk("ur_gate", {31'd0, gate}, 32'd0);
          active = 1'b0;
        end
      end
    end else if (note_done) begin
      chk("stray_note_done", {31'd0, note_done}, 32'd0);
    end else if (!busy) begin
      active = 1'b0;
    end else if (active) begin
      chk("hold_step", {16'd0, step}, {16'd0, cur_step});
      chk("hold_gate", {31'd0, gate}, {31'd0, cur_gate});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_note(input logic [15:0] s, input logic [1:0] d, input logic [7:0] du, input logic r);
    note_step  = s;
    note_duty  = d;
    note_dur   = du;
    note_rest  = r;
    note_valid = 1'b1;
    cyc();
    note_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  // Run until every expected event has been seen, bounded.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      cyc();
      k++;
    end
    if (sb.size() != 0) begin
      chk(name, sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // Wait for the next phase_clr, bounded.
  task automatic wait_pc(input string name);
    int k;
    k = 0;
    while (phase_clr !== 1'b1 && k < 100) begin
      cyc();
      k++;
    end
    if (phase_clr !== 1'b1) begin
      chk(name, {31'd0, phase_clr}, 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step"},      {16'd0, step},       32'd0);
    chk({tag, "_duty"},      {30'd0, duty},       32'd0);
    chk({tag, "_gate"},      {31'd0, gate},       32'd0);
    chk({tag, "_pulses"},    {29'd0, phase_clr, note_done, underrun}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},       32'd0);
    chk({tag, "_level"},     {29'd0, level},      32'd0);
    chk({tag, "_ready"},     {31'd0, note_ready}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    note_valid = 1'b0;
    note_step  = 16'h0000;
    note_duty  = 2'd0;
    note_dur   = 8'd0;
    note_rest  = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    cyc();

    // Single note, dur=2: 8 cycles of tone then underrun, back to ARMED.
    exp_pc(16'h0100, 2'd1, 1'b1, -1);
    exp_ur(8);
    push_note(16'h0100, 2'd1, 8'd2, 1'b0);
    chk("single_level", {29'd0, level}, 32'd1);
    pulse_start();
    drain("single_drain");
    chk("single_armed_busy", {31'd0, busy}, 32'd1);
    chk("single_silent_step", {16'd0, step}, 32'd0);
    chk("single_duty_held", {30'd0, duty}, 32'd1);
    pulse_stop();
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Gapless run: durations 1, 3, 0 -> spacing 4, 12, 4.
    exp_pc(16'h0200, 2'd2, 1'b1, -1);
    exp_pc(16'h0300, 2'd3, 1'b1, 4);
    exp_pc(16'h0400, 2'd0, 1'b1, 12);
    exp_ur(4);
    push_note(16'h0200, 2'd2, 8'd1, 1'b0);
    push_note(16'h0300, 2'd3, 8'd3, 1'b0);
    push_note(16'h0400, 2'd0, 8'd0, 1'b0);
    chk("gapless_level", {29'd0, level}, 32'd3);
    pulse_start();
    drain("gapless_drain");
    pulse_stop();

    // Fill to DEPTH while IDLE; a 5th push is refused.
    exp_pc(16'h0500, 2'd1, 1'b1, -1);
    exp_pc(16'h0600, 2'd1, 1'b1, 4);
    exp_pc(16'h0700, 2'd1, 1'b1, 4);
    exp_pc(16'h0800, 2'd1, 1'b1, 4);
    exp_ur(4);
    push_note(16'h0500, 2'd1, 8'd1, 1'b0);
    push_note(16'h0600, 2'd1, 8'd1, 1'b0);
    push_note(16'h0700, 2'd1, 8'd1, 1'b0);
    chk("fill3_ready", {31'd0, note_ready}, 32'd1);
    push_note(16'h0800, 2'd1, 8'd1, 1'b0);
    chk("full_ready", {31'd0, note_ready}, 32'd0);
    chk("full_level", {29'd0, level}, 32'd4);
    push_note(16'h0900, 2'd1, 8'd1, 1'b0);
    chk("full_reject_level", {29'd0, level}, 32'd4);
    pulse_start();
    chk("armed_ready", {31'd0, note_ready}, 32'd0);
    cyc();
    chk("pop_ready", {31'd0, note_ready}, 32'd1);
    chk("pop_level", {29'd0, level}, 32'd3);
    chk("pop_phase_clr", {31'd0, phase_clr}, 32'd1);
    drain("fill_drain");
    pulse_stop();

    // Rest note between two tones.
    exp_pc(16'h0A00, 2'd1, 1'b1, -1);
    exp_pc(16'h0000, 2'd2, 1'b0, 4);
    exp_pc(16'h0C00, 2'd3, 1'b1, 8);
    exp_ur(4);
    push_note(16'h0A00, 2'd1, 8'd1, 1'b0);
    push_note(16'h0B00, 2'd2, 8'd2, 1'b1);
    push_note(16'h0C00, 2'd3, 8'd1, 1'b0);
    pulse_start();
    drain("rest_drain");
    pulse_stop();

    // Stop two cycles into a note; start+stop together stays IDLE.
    exp_pc(16'h0D00, 2'd1, 1'b1, -1);
    push_note(16'h0D00, 2'd1, 8'd3, 1'b0);
    push_note(16'h0E00, 2'd1, 8'd1, 1'b0);
    pulse_start();
    wait_pc("stop_wait_pc");
    cyc();
    pulse_stop();
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_step", {16'd0, step}, 32'd0);
    chk("stop_gate", {31'd0, gate}, 32'd0);
    chk("stop_level", {29'd0, level}, 32'd1);
    chk("stop_sb_empty", sb.size(), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", {31'd0, busy}, 32'd0);
    cyc();
    chk("start_stop_idle2", {31'd0, busy}, 32'd0);
    pulse_flush();
    chk("flush_idle_level", {29'd0, level}, 32'd0);

    // Asynchronous reset mid-PLAY with two notes queued.
    exp_pc(16'h1000, 2'd1, 1'b1, -1);
    push_note(16'h1000, 2'd1, 8'd3, 1'b0);
    push_note(16'h1100, 2'd2, 8'd1, 1'b0);
    push_note(16'h1200, 2'd3, 8'd1, 1'b0);
    pulse_start();
    wait_pc("rst_wait_pc");
    cyc();
    chk("rst_pre_level", {29'd0, level}, 32'd2);
    chk("rst_pre_gate", {31'd0, gate}, 32'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    chk("rst_sb_empty", sb.size(), 32'd0);

    // Flush during PLAY: the current note finishes, then underrun.
    exp_pc(16'h1300, 2'd1, 1'b1, -1);
    exp_ur(8);
    push_note(16'h1300, 2'd1, 8'd2, 1'b0);
    push_note(16'h1400, 2'd2, 8'd1, 1'b0);
    pulse_start();
    wait_pc("flush_wait_pc");
    pulse_flush();
    chk("flush_play_level", {29'd0, level}, 32'd0);
    drain("flush_drain");
    chk("flush_armed", {31'd0, busy}, 32'd1);

    repeat (4) cyc();
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/square_sequencer.md
# square_sequencer

Note sequencer that drives the `step`/`duty` controls of a square-wave generator. Software or an upstream block pushes notes (pitch step, duty code, duration, rest flag) into an internal FIFO. The sequencer plays them back-to-back on a tick timebase and emits a phase-clear pulse at each note start. It sits directly in front of the square-wave oscillator and owns its pitch, duty and restart.

## Interface
Parameters:
- `DEPTH`, 8: note FIFO entries; power of two, ≥2.
- `TICK_DIV`, 48000: clock cycles per duration tick; ≥2.
- `DUR_W`, 8: duration field width in ticks.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `note_valid`  in  1  note offered.
- `note_ready`  out  1  FIFO can accept; equals `!full`.
- `note_step`  in  16  phase increment for the note.
- `note_duty`  in  2  duty code, passed through unchanged.
- `note_dur`  in  DUR_W  duration in ticks; 0 is treated as 1.
- `note_rest`  in  1  silent note: duration only, no tone.
- `start`  in  1  pulse; arms playback.
- `stop`  in  1  pulse; halts playback, FIFO retained.
- `flush`  in  1  pulse; empties the FIFO.
- `step`  out  16  to oscillator step; 0 when silent.
- `duty`  out  2  to oscillator duty.
- `gate`  out  1  1 while a non-rest note sounds.
- `phase_clr`  out  1  one-cycle pulse at each note start; drives the oscillator reset.
- `note_done`  out  1  one-cycle pulse when a note's duration expires.
- `underrun`  out  1  one-cycle pulse when a note ends and the FIFO is empty.
- `busy`  out  1  state is not IDLE.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states:
  - IDLE: `start` → ARMED.
  - ARMED: FIFO non-empty → pop the head, load the note registers, pulse `phase_clr`, clear the prescaler and load `dur_cnt` → PLAY.
  - PLAY: the prescaler counts 0..TICK_DIV-1, and `tick` asserts at TICK_DIV-1. Each tick decrements `dur_cnt`. On the tick where `dur_cnt`==1:
    - pulse `note_done`;
    - if the FIFO is non-empty, pop and load the next note in the same cycle, pulse `phase_clr`, stay in PLAY (gapless);
    - else pulse `underrun`, silence the outputs, go to ARMED.
- `stop` in any state → IDLE next cycle. Outputs silence and the current note is discarded.
- Priority: `stop` beats `start` in the same cycle; `stop` beats a pending pop.
- `start` while not in IDLE is ignored.
- Silence means `step`=0, `gate`=0, `duty` held at its last value.
- Rest note: loaded like any note, but `step`=0 and `gate`=0 for its duration. `phase_clr` still pulses.
- FIFO behaviour:
  - A push is accepted when `note_valid && note_ready`.
  - A push and a pop in the same cycle is legal at any non-full level.
  - `flush` clears the pointers.
  - When `flush` coincides with a push, the push is dropped.
  - When `flush` coincides with a pop, the popped note still loads.
- Reset values: state IDLE, FIFO empty. `step`=0, `duty`=0, `gate`=0, all pulses 0, `busy`=0, `level`=0, `note_ready`=1.
- `reset_n` asserted mid-note returns everything to the reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Push into an empty FIFO while ARMED at cycle N:
  - `level`=1 at N+1;
  - pop at N+1;
  - `step`/`duty`/`gate`/`phase_clr` valid at N+2.
- A note lasts exactly `max(dur,1)*TICK_DIV` cycles, measured from `phase_clr` to the next `phase_clr` (gapless) or to silence.
- `note_done` and the next note's `phase_clr` fall in the same cycle.
- `level` updates one cycle after a push or pop.
- `note_ready` deasserts in the cycle `level` reaches DEPTH.

## Structure
- Package `square_seq_pkg`:
  - state enum `seq_state_t` {IDLE, ARMED, PLAY};
  - packed struct `note_t` {rest, dur, duty, step};
  - duty code constants shared with the oscillator.
- Sub-module `note_fifo`:
  - synchronous DEPTH×`note_t` FIFO with push/pop/flush, `full`, `empty` and `level`;
  - one extra pointer bit for full/empty detection.
- The top level holds the FSM, prescaler, duration counter and output registers.

## Test plan
Use TICK_DIV=4 and DEPTH=4 for the bench.
- Reset, then push {step=0x0100, duty=1, dur=2}, then `start` → `phase_clr` once, `step`=0x0100 and `gate`=1 for exactly 8 cycles, then `note_done`, `underrun`, `step`=0, state ARMED.
- Push 3 notes (dur 1, 3, 0), then `start` → `phase_clr` spacing of 4, 12 and 4 cycles with no silent cycles between them; `underrun` after the third.
- Fill the FIFO with 4 notes while IDLE → `note_ready`=0 and `level`=4; a 5th push is not accepted. Then `start` → first pop, and `note_ready`=1 on the next cycle.
- Push a rest note with dur=2 between two tones → `step`=0 and `gate`=0 for 8 cycles, `phase_clr` still pulses.
- `stop` two cycles into a note → IDLE next cycle, `step`=0, `level` unchanged. Assert `start` and `stop` together → stays IDLE.
- Assert `reset_n` low mid-PLAY with the FIFO at 2 → all outputs return to reset values asynchronously and `level`=0. `flush` during PLAY → `level`=0 and `underrun` at the end of the current note.
